// File: rtl/pipe_hazard_unit.sv
// Hazard, stall and forwarding controller for the pipelined MIPS core.
// A shift-register scoreboard tracks in-flight instructions from EX (entry 0) to WB.
module pipe_hazard_unit #(
  parameter int unsigned STAGES         = 3,
  parameter int unsigned LOAD_FWD_STAGE = 2,
  parameter int unsigned REG_W          = 5,
  parameter int unsigned COUNT_W        = 16,
  localparam int unsigned FWD_W         = $clog2(STAGES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid_i,
  input  logic [REG_W-1:0]   id_rs_i,
  input  logic [REG_W-1:0]   id_rt_i,
  input  logic               id_uses_rs_i,
  input  logic               id_uses_rt_i,
  input  logic               id_wr_en_i,
  input  logic [REG_W-1:0]   id_dst_i,
  input  logic               id_is_load_i,
  input  logic               id_jump_i,
  input  logic               ex_branch_taken_i,
  output logic               pc_write_o,
  output logic               ifid_write_o,
  output logic               ifid_flush_o,
  output logic               idex_bubble_o,
  output logic [FWD_W-1:0]   fwd_a_o,
  output logic [FWD_W-1:0]   fwd_b_o,
  output logic [COUNT_W-1:0] stall_count_o,
  output logic [COUNT_W-1:0] flush_count_o
);

  logic             sb_valid [STAGES];
  logic             sb_wr_en [STAGES];
  logic             sb_load  [STAGES];
  logic [REG_W-1:0] sb_dst   [STAGES];
  // Source registers are only needed for the instruction sitting in EX.
  logic [REG_W-1:0] ex_rs;
  logic [REG_W-1:0] ex_rt;

  logic [STAGES-1:0] prod_ok;
  logic              load_hit;
  logic              stall_c;
  logic              bubble_c;
  logic              flush_c;
  logic [COUNT_W-1:0] stall_cnt;
  logic [COUNT_W-1:0] flush_cnt;

  // An entry can produce a value when it is real, writes, and does not target $0.
  always_comb begin
    prod_ok = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      prod_ok[k] = sb_valid[k] && sb_wr_en[k] && (sb_dst[k] != '0);
    end
  end

  // Load-use: a load whose data is not yet forwardable blocks a consumer in ID.
  always_comb begin
    load_hit = 1'b0;
    for (int k = 0; k < int'(STAGES); k++) begin
      if (((k + 1) < int'(LOAD_FWD_STAGE)) && prod_ok[k] && sb_load[k] &&
          ((id_uses_rs_i && (sb_dst[k] == id_rs_i)) ||
           (id_uses_rt_i && (sb_dst[k] == id_rt_i)))) begin
        load_hit = 1'b1;
      end
    end
  end

  assign stall_c  = id_valid_i && !ex_branch_taken_i && load_hit;
  assign bubble_c = stall_c || ex_branch_taken_i;
  assign flush_c  = ex_branch_taken_i || (id_jump_i && id_valid_i && !stall_c);

  assign pc_write_o    = !stall_c;
  assign ifid_write_o  = !stall_c;
  assign ifid_flush_o  = flush_c;
  assign idex_bubble_o = bubble_c;
  assign stall_count_o = stall_cnt;
  assign flush_count_o = flush_cnt;

  // Descending scan so the youngest matching producer wins.
  always_comb begin
    fwd_a_o = '0;
    fwd_b_o = '0;
    for (int k = int'(STAGES) - 1; k >= 1; k--) begin
      if (sb_valid[0] && prod_ok[k] && (sb_dst[k] == ex_rs)) fwd_a_o = FWD_W'(k);
      if (sb_valid[0] && prod_ok[k] && (sb_dst[k] == ex_rt)) fwd_b_o = FWD_W'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < int'(STAGES); k++) sb_valid[k] <= 1'b0;
    end else begin
      sb_valid[0] <= id_valid_i && !bubble_c;
      for (int k = 1; k < int'(STAGES); k++) sb_valid[k] <= sb_valid[k-1];
    end
  end

  // Payload fields shift unconditionally; they are qualified by sb_valid.
  always_ff @(posedge clk) begin
    sb_wr_en[0] <= id_wr_en_i;
    sb_load[0]  <= id_is_load_i;
    sb_dst[0]   <= id_dst_i;
    ex_rs       <= id_rs_i;
    ex_rt       <= id_rt_i;
    for (int k = 1; k < int'(STAGES); k++) begin
      sb_wr_en[k] <= sb_wr_en[k-1];
      sb_load[k]  <= sb_load[k-1];
      sb_dst[k]   <= sb_dst[k-1];
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + COUNT_W'(1);
      if (flush_c && (flush_cnt != '1)) flush_cnt <= flush_cnt + COUNT_W'(1);
    end
  end

endmodule
